// File: rtl/conv_tile_controller.sv
// rtl/conv_tile_controller.sv - conv-layer tile sequencer for MAC datapath, operand fetch and psum memory
//
// Ports:
//   clk, arst_n_in                      clock, asynchronous active-low reset
//   start, cfg_*                        layer start and configuration (latched on accepted start)
//   running, cfg_err                    status; cfg_err pulses the cycle after a start with a zero field
//   data_ready, a_ready, b_ready        per-tile operand load handshake
//   int_mem_re, write_a, write_b        operand fetch strobes
//   mac_valid, mac_accumulate_*         MAC datapath controls
//   mem_re, mem_we, mem_*_addr          psum memory read/write (address = output channel)
//   ky_out..x_out                       fetch-stage loop counters (x absolute)
//   output_valid, output_x/y/ch         finished output pixel and its coordinates
//   tile_done, fsm_done                 end-of-tile / end-of-layer pulses
//   perf_cycles, perf_stalls            only with CTRL_PERF_COUNTERS_EN defined
//
// Optional feature macro: CTRL_PERF_COUNTERS_EN

module conv_tile_controller #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int DIM_W              = 16,
    parameter int TILE_WIDTH         = 64
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    input  logic [DIM_W-1:0]              cfg_width,
    input  logic [DIM_W-1:0]              cfg_height,
    input  logic [DIM_W-1:0]              cfg_in_ch,
    input  logic [DIM_W-1:0]              cfg_out_ch,
    input  logic [DIM_W-1:0]              cfg_kernel,
    output logic                          running,
    output logic                          cfg_err,
    input  logic                          data_ready,
    output logic                          a_ready,
    output logic                          b_ready,
    output logic                          int_mem_re,
    output logic                          write_a,
    output logic                          write_b,
    output logic                          mac_valid,
    output logic                          mac_accumulate_internal,
    output logic                          mac_accumulate_with_0,
    output logic                          mem_re,
    output logic                          mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
    output logic [DIM_W-1:0]              ky_out,
    output logic [DIM_W-1:0]              kx_out,
    output logic [DIM_W-1:0]              inch_out,
    output logic [DIM_W-1:0]              outch_out,
    output logic [DIM_W-1:0]              y_out,
    output logic [DIM_W-1:0]              x_out,
    output logic                          output_valid,
    output logic [DIM_W-1:0]              output_x,
    output logic [DIM_W-1:0]              output_y,
    output logic [DIM_W-1:0]              output_ch,
    output logic                          tile_done,
    output logic                          fsm_done
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [31:0]                   perf_cycles,
    output logic [31:0]                   perf_stalls
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH, S_MAC} state_t;

    // One loop-nest position; x is absolute within the feature map.
    typedef struct packed {
        logic [DIM_W-1:0] x;
        logic [DIM_W-1:0] y;
        logic [DIM_W-1:0] ci;
        logic [DIM_W-1:0] co;
        logic [DIM_W-1:0] ky;
        logic [DIM_W-1:0] kx;
    } point_t;

    state_t           state, state_next;
    logic [DIM_W-1:0] cw, chh, cin, cout, ck;
    logic [DIM_W-1:0] tile_base;
    point_t           f_pt, m_pt;
    logic             fetch_done;

    logic [DIM_W:0]   tile_sum;
    logic             last_tile;
    logic [DIM_W-1:0] tile_end, x_last;
    logic [DIM_W-1:0] k_max, ci_max, co_max, y_max;
    logic             cfg_ok, accept, mac_last, fetch_last;
    logic             window_start, window_end;

    // Tile bounds: widened sum so tile_base + TILE_WIDTH cannot wrap.
    assign tile_sum  = {1'b0, tile_base} + (DIM_W+1)'(TILE_WIDTH);
    assign last_tile = tile_sum >= {1'b0, cw};
    assign tile_end  = last_tile ? cw : tile_sum[DIM_W-1:0];
    assign x_last    = tile_end - 1'b1;
    assign k_max     = ck - 1'b1;
    assign ci_max    = cin - 1'b1;
    assign co_max    = cout - 1'b1;
    assign y_max     = chh - 1'b1;

    assign cfg_ok = (cfg_width != '0) && (cfg_height != '0) && (cfg_in_ch != '0) &&
                    (cfg_out_ch != '0) && (cfg_kernel != '0);
    assign accept = (state == S_IDLE) && start && cfg_ok;

    // Advance one position in loop order tile > x > y > ci > co > ky > kx.
    function automatic point_t step_point(input point_t p);
        point_t n;
        n = p;
        if (p.kx != k_max) n.kx = p.kx + 1'b1;
        else begin
            n.kx = '0;
            if (p.ky != k_max) n.ky = p.ky + 1'b1;
            else begin
                n.ky = '0;
                if (p.co != co_max) n.co = p.co + 1'b1;
                else begin
                    n.co = '0;
                    if (p.ci != ci_max) n.ci = p.ci + 1'b1;
                    else begin
                        n.ci = '0;
                        if (p.y != y_max) n.y = p.y + 1'b1;
                        else begin
                            n.y = '0;
                            n.x = (p.x != x_last) ? p.x + 1'b1 : tile_base;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    function automatic logic is_last(input point_t p);
        return (p.kx == k_max) && (p.ky == k_max) && (p.co == co_max) &&
               (p.ci == ci_max) && (p.y == y_max) && (p.x == x_last);
    endfunction

    function automatic point_t tile_origin(input logic [DIM_W-1:0] base);
        point_t n;
        n   = '0;
        n.x = base;
        return n;
    endfunction

    assign mac_last   = is_last(m_pt);
    assign fetch_last = is_last(f_pt);

    always_comb begin
        state_next = state;
        int_mem_re = 1'b0;
        mac_valid  = 1'b0;
        tile_done  = 1'b0;
        fsm_done   = 1'b0;
        case (state)
            S_IDLE:  if (accept) state_next = S_LOAD;
            S_LOAD:  if (data_ready) state_next = S_FETCH;
            S_FETCH: begin
                int_mem_re = 1'b1;
                state_next = S_MAC;
            end
            S_MAC: begin
                mac_valid  = 1'b1;
                int_mem_re = !fetch_done;
                if (mac_last) begin
                    if (last_tile) begin
                        fsm_done   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        tile_done  = 1'b1;
                        state_next = S_LOAD;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign running  = (state != S_IDLE);
    assign a_ready  = running;
    assign b_ready  = running;
    assign write_a  = int_mem_re;
    assign write_b  = int_mem_re;

    assign window_start            = (m_pt.ky == '0) && (m_pt.kx == '0);
    assign window_end              = (m_pt.ci == ci_max) && (m_pt.ky == k_max) && (m_pt.kx == k_max);
    assign mac_accumulate_internal = mac_valid && !window_start;
    assign mac_accumulate_with_0   = mac_valid && window_start && (m_pt.ci == '0);
    assign mem_re                  = mac_valid && window_start;
    assign mem_read_addr           = LOG2_OF_MEM_HEIGHT'(m_pt.co);

    assign ky_out    = f_pt.ky;
    assign kx_out    = f_pt.kx;
    assign inch_out  = f_pt.ci;
    assign outch_out = f_pt.co;
    assign y_out     = f_pt.y;
    assign x_out     = f_pt.x;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state          <= S_IDLE;
            cw             <= '0;
            chh            <= '0;
            cin            <= '0;
            cout           <= '0;
            ck             <= '0;
            tile_base      <= '0;
            f_pt           <= '0;
            m_pt           <= '0;
            fetch_done     <= 1'b0;
            cfg_err        <= 1'b0;
            mem_we         <= 1'b0;
            mem_write_addr <= '0;
            output_valid   <= 1'b0;
            output_x       <= '0;
            output_y       <= '0;
            output_ch      <= '0;
        end else begin
            state   <= state_next;
            cfg_err <= (state == S_IDLE) && start && !cfg_ok;

            if (accept) begin
                cw         <= cfg_width;
                chh        <= cfg_height;
                cin        <= cfg_in_ch;
                cout       <= cfg_out_ch;
                ck         <= cfg_kernel;
                tile_base  <= '0;
                f_pt       <= '0;
                m_pt       <= '0;
                fetch_done <= 1'b0;
            end else if (tile_done) begin
                tile_base  <= tile_end;
                f_pt       <= tile_origin(tile_end);
                m_pt       <= tile_origin(tile_end);
                fetch_done <= 1'b0;
            end else if (fsm_done) begin
                tile_base  <= '0;
                f_pt       <= '0;
                m_pt       <= '0;
                fetch_done <= 1'b0;
            end else begin
                if (int_mem_re) begin
                    f_pt <= step_point(f_pt);
                    if (fetch_last) fetch_done <= 1'b1;
                end
                if (mac_valid) m_pt <= step_point(m_pt);
            end

            // Write-back trails the psum read by the MAC-stage latency of one cycle.
            mem_we         <= mem_re;
            mem_write_addr <= mem_read_addr;

            output_valid <= mac_valid && window_end;
            if (mac_valid && window_end) begin
                output_x  <= m_pt.x;
                output_y  <= m_pt.y;
                output_ch <= m_pt.co;
            end
        end
    end

`ifdef CTRL_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (running) begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
            if (state == S_LOAD && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_tile_controller.sv
// tb/tb_conv_tile_controller.sv - self-checking bench for conv_tile_controller
module tb_conv_tile_controller;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int TW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst_n_in, start, data_ready;
    logic [DW-1:0] cfg_width, cfg_height, cfg_in_ch, cfg_out_ch, cfg_kernel;
    logic          running, cfg_err, a_ready, b_ready, int_mem_re, write_a, write_b;
    logic          mac_valid, acc_int, acc0, mem_re, mem_we;
    logic [AW-1:0] mem_read_addr, mem_write_addr;
    logic [DW-1:0] ky_out, kx_out, inch_out, outch_out, y_out, x_out;
    logic          output_valid, tile_done, fsm_done;
    logic [DW-1:0] output_x, output_y, output_ch;
`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    conv_tile_controller #(.LOG2_OF_MEM_HEIGHT(AW), .DIM_W(DW), .TILE_WIDTH(TW)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_in_ch(cfg_in_ch),
        .cfg_out_ch(cfg_out_ch), .cfg_kernel(cfg_kernel),
        .running(running), .cfg_err(cfg_err), .data_ready(data_ready),
        .a_ready(a_ready), .b_ready(b_ready), .int_mem_re(int_mem_re),
        .write_a(write_a), .write_b(write_b), .mac_valid(mac_valid),
        .mac_accumulate_internal(acc_int), .mac_accumulate_with_0(acc0),
        .mem_re(mem_re), .mem_we(mem_we), .mem_read_addr(mem_read_addr),
        .mem_write_addr(mem_write_addr), .ky_out(ky_out), .kx_out(kx_out),
        .inch_out(inch_out), .outch_out(outch_out), .y_out(y_out), .x_out(x_out),
        .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
        .output_ch(output_ch), .tile_done(tile_done), .fsm_done(fsm_done)
`ifdef CTRL_PERF_COUNTERS_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    typedef struct {
        int w, h, cin, cout, k, dly;
        int exp_mac, exp_out, exp_tdone, exp_loads, exp_memre, exp_stalls;
        bit chk_perf;
    } vec_t;

    typedef struct { int x, y, ci, co, ky, kx; } pt_t;

    vec_t vecs[5];
    pt_t  model[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_model(input vec_t v);
        pt_t p;
        model.delete();
        for (int tb = 0; tb < v.w; tb += TW) begin
            int te;
            te = (tb + TW < v.w) ? tb + TW : v.w;
            for (int x = tb; x < te; x++)
                for (int y = 0; y < v.h; y++)
                    for (int ci = 0; ci < v.cin; ci++)
                        for (int co = 0; co < v.cout; co++)
                            for (int ky = 0; ky < v.k; ky++)
                                for (int kx = 0; kx < v.k; kx++) begin
                                    p.x = x; p.y = y; p.ci = ci; p.co = co; p.ky = ky; p.kx = kx;
                                    model.push_back(p);
                                end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {running, a_ready, b_ready, int_mem_re, write_a, write_b, mac_valid,
                             acc_int, acc0, mem_re, mem_we, output_valid, tile_done, fsm_done, cfg_err}, 0);
        chk({tag, "_cnt"}, {ky_out, kx_out, inch_out, outch_out, y_out, x_out}, 0);
        chk({tag, "_out"}, {output_x, output_y, output_ch, mem_read_addr, mem_write_addr}, 0);
    endtask

    // Runs one layer with a scoreboard; abort_after > 0 asserts reset after that many MAC cycles.
    task automatic run_layer(input vec_t v, input int abort_after);
        int fi, mi, mac_cnt, out_cnt, tdone, fdone, loads, memre_cnt, run_cnt, load_cyc, max_x, cyc;
        bit in_load, in_load_prev, exp_ov, exp_we, finish_next, aborted;
        int exp_ox, exp_oy, exp_och, exp_wa;
        pt_t p;
        build_model(v);
        fi = 0; mi = 0; mac_cnt = 0; out_cnt = 0; tdone = 0; fdone = 0; loads = 0;
        memre_cnt = 0; run_cnt = 0; load_cyc = 0; max_x = -1;
        in_load_prev = 0; exp_ov = 0; exp_we = 0; finish_next = 0; aborted = 0;
        exp_ox = 0; exp_oy = 0; exp_och = 0; exp_wa = 0;

        @(negedge clk);
        cfg_width = DW'(v.w); cfg_height = DW'(v.h); cfg_in_ch = DW'(v.cin);
        cfg_out_ch = DW'(v.cout); cfg_kernel = DW'(v.k); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs scrambled after acceptance must not affect the run.
        cfg_width = DW'(v.w + 7); cfg_height = DW'(v.h + 1); cfg_in_ch = 3;
        cfg_out_ch = 5; cfg_kernel = DW'(v.k + 2);

        for (cyc = 0; cyc < 5000; cyc++) begin
            in_load = running && a_ready && !int_mem_re && !mac_valid;
            if (in_load && !in_load_prev) begin
                loads++;
                load_cyc = 0;
            end
            if (running) run_cnt++;

            chk("output_valid", output_valid, exp_ov);
            if (exp_ov && output_valid) begin
                chk("output_x", output_x, exp_ox);
                chk("output_y", output_y, exp_oy);
                chk("output_ch", output_ch, exp_och);
            end
            chk("mem_we", mem_we, exp_we);
            if (exp_we && mem_we) chk("mem_write_addr", mem_write_addr, exp_wa);
            if (output_valid) begin
                out_cnt++;
                if (int'(output_x) > max_x) max_x = int'(output_x);
            end

            chk("fetch_strobes", {write_a, write_b}, {int_mem_re, int_mem_re});
            if (int_mem_re) begin
                if (fi < model.size()) begin
                    p = model[fi];
                    chk("x_out", x_out, p.x);
                    chk("y_out", y_out, p.y);
                    chk("inch_out", inch_out, p.ci);
                    chk("outch_out", outch_out, p.co);
                    chk("ky_out", ky_out, p.ky);
                    chk("kx_out", kx_out, p.kx);
                end else chk("fetch_overrun", fi, model.size() - 1);
                fi++;
            end

            exp_ov = 0;
            exp_we = 0;
            if (mac_valid) begin
                if (mi < model.size()) begin
                    p = model[mi];
                    chk("mac_lags_fetch", (mi < fi), 1);
                    chk("acc_internal", acc_int, !(p.ky == 0 && p.kx == 0));
                    chk("acc_with_0", acc0, (p.ci == 0 && p.ky == 0 && p.kx == 0));
                    chk("mem_re", mem_re, (p.ky == 0 && p.kx == 0));
                    if (p.ky == 0 && p.kx == 0) chk("mem_read_addr", mem_read_addr, p.co);
                    exp_ov  = (p.ci == v.cin - 1 && p.ky == v.k - 1 && p.kx == v.k - 1);
                    exp_ox  = p.x; exp_oy = p.y; exp_och = p.co;
                    exp_we  = (p.ky == 0 && p.kx == 0);
                    exp_wa  = p.co;
                end else chk("mac_overrun", mi, model.size() - 1);
                mi++;
                mac_cnt++;
            end else chk("mem_re_idle", mem_re, 0);
            if (mem_re) memre_cnt++;
            if (tile_done) tdone++;
            if (fsm_done) fdone++;

            data_ready = in_load && (load_cyc >= v.dly);
            if (in_load) load_cyc++;
            in_load_prev = in_load;
            // A start pulse while busy must be ignored.
            start = (cyc == 5) && running;

            if (abort_after > 0 && mac_cnt == abort_after) begin
                arst_n_in = 1'b0;
                #1;
                check_all_zero("abort");
                aborted = 1;
                break;
            end
            if (finish_next) break;
            if (fsm_done) finish_next = 1;
            @(negedge clk);
        end
        start = 1'b0;
        data_ready = 1'b0;

        if (!aborted) begin
            chk("timeout", (cyc < 5000), 1);
            chk("mac_count", mac_cnt, v.exp_mac);
            chk("out_count", out_cnt, v.exp_out);
            chk("tile_done_count", tdone, v.exp_tdone);
            chk("fsm_done_count", fdone, 1);
            chk("load_count", loads, v.exp_loads);
            chk("mem_re_count", memre_cnt, v.exp_memre);
            chk("fetch_count", fi, v.exp_mac);
            chk("max_output_x", max_x, v.w - 1);
            chk("running_end", running, 0);
`ifdef CTRL_PERF_COUNTERS_EN
            if (v.chk_perf) begin
                chk("perf_stalls", perf_stalls, v.exp_stalls);
                chk("perf_cycles", perf_cycles, run_cnt);
            end
`endif
        end
    endtask

    initial begin
        //          w    h  cin cout k  dly  mac  out tdone loads memre stalls perf
        vecs[0] = '{4,   2, 2,  2,  3, 3,   288, 16,  0,    1,    32,   4,   1'b1};
        vecs[1] = '{130, 1, 1,  1,  1, 1,   130, 130, 2,    3,    130,  6,   1'b0};
        vecs[2] = '{3,   2, 2,  2,  2, 0,   96,  12,  0,    1,    24,   1,   1'b0};
        vecs[3] = '{65,  1, 1,  2,  1, 2,   130, 130, 1,    2,    130,  6,   1'b0};
        vecs[4] = '{1,   1, 1,  1,  1, 0,   1,   1,   0,    1,    1,    1,   1'b0};

        arst_n_in = 1'b0; start = 1'b0; data_ready = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_in_ch = '0; cfg_out_ch = '0; cfg_kernel = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        arst_n_in = 1'b1;
        @(negedge clk);

        // Start with a zero kernel size: error pulse, no run.
        cfg_width = 4; cfg_height = 2; cfg_in_ch = 2; cfg_out_ch = 2; cfg_kernel = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_running", running, 0);
        @(negedge clk);
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_err_still_idle", running, 0);

        foreach (vecs[i]) run_layer(vecs[i], 0);

        // Reset mid-MAC, then a clean rerun must reproduce the full sequence.
        run_layer(vecs[0], 50);
        @(negedge clk);
        check_all_zero("held_reset");
        arst_n_in = 1'b1;
        @(negedge clk);
        run_layer(vecs[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
